// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and default phase lengths for the junction controller
package traffic_pkg;

   typedef enum logic [2:0] {
      ALL_RED   = 3'd0,
      RED_AMBER = 3'd1,
      GREEN     = 3'd2,
      AMBER     = 3'd3,
      WALK      = 3'd4
   } state_t;

   localparam int DEF_N_APPROACH    = 2;
   localparam int DEF_ALLRED_CYCLES = 1;
   localparam int DEF_RA_CYCLES     = 2;
   localparam int DEF_GREEN_CYCLES  = 8;
   localparam int DEF_AMBER_CYCLES  = 3;
   localparam int DEF_WALK_CYCLES   = 6;
   localparam int DEF_CNT_W         = 8;

   // Width of the approach index; a single approach still gets one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that flags the last cycle of a phase
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // Load wins over decrement; the count parks at zero instead of wrapping.
   always_ff @(posedge clk) begin
      if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/traffic_junction.sv
// rtl/traffic_junction.sv - round-robin junction controller with latched pedestrian walk phase
module traffic_junction
   import traffic_pkg::*;
#(
   parameter int N_APPROACH    = DEF_N_APPROACH,
   parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES,
   parameter int RA_CYCLES     = DEF_RA_CYCLES,
   parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
   parameter int AMBER_CYCLES  = DEF_AMBER_CYCLES,
   parameter int WALK_CYCLES   = DEF_WALK_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enable,
   input  logic                                ped_req,
   output logic [N_APPROACH-1:0]               red,
   output logic [N_APPROACH-1:0]               amber,
   output logic [N_APPROACH-1:0]               green,
   output logic                                walk,
   output logic [idx_width(N_APPROACH)-1:0]    active_idx,
   output logic                                ped_pending
);

   localparam int IDX_W = idx_width(N_APPROACH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_APPROACH - 1);

   state_t                state;
   state_t                next_state;
   logic                  timer_done;
   logic                  timer_load;
   logic                  advance;
   logic [CNT_W-1:0]      load_val;
   logic [N_APPROACH-1:0] onehot;

   // Phase length minus one, i.e. the counter value that gives exactly that many cycles.
   function automatic logic [CNT_W-1:0] reload(input state_t s);
      case (s)
         RED_AMBER: return CNT_W'(RA_CYCLES - 1);
         GREEN:     return CNT_W'(GREEN_CYCLES - 1);
         AMBER:     return CNT_W'(AMBER_CYCLES - 1);
         WALK:      return CNT_W'(WALK_CYCLES - 1);
         default:   return CNT_W'(ALLRED_CYCLES - 1);
      endcase
   endfunction

   assign advance    = enable & timer_done;
   assign timer_load = rst | advance;
   assign load_val   = rst ? CNT_W'(ALLRED_CYCLES - 1) : reload(next_state);
   assign onehot     = N_APPROACH'(1) << active_idx;

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .load     (timer_load),
      .load_val (load_val),
      .en       (enable),
      .done     (timer_done)
   );

   // State register; reset aborts whatever phase is in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ALL_RED;
      end else begin
         state <= next_state;
      end
   end

   // Approach pointer moves on only when its amber phase finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_idx <= '0;
      end else if (advance && (state == AMBER)) begin
         active_idx <= (active_idx == LAST_IDX) ? '0 : active_idx + 1'b1;
      end
   end

   // Pedestrian latch: presses during the walk itself are dropped, leaving the walk clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ped_pending <= 1'b0;
      end else if (state == WALK) begin
         if (advance) begin
            ped_pending <= 1'b0;
         end
      end else if (ped_req) begin
         ped_pending <= 1'b1;
      end
   end

   // Next-state selection and Moore lamp decode from the registered state.
   always_comb begin
      next_state = state;
      red        = '1;
      amber      = '0;
      green      = '0;
      walk       = 1'b0;

      if (advance) begin
         case (state)
            ALL_RED:   next_state = ped_pending ? WALK : RED_AMBER;
            RED_AMBER: next_state = GREEN;
            GREEN:     next_state = AMBER;
            AMBER:     next_state = ALL_RED;
            WALK:      next_state = ALL_RED;
            default:   next_state = ALL_RED;
         endcase
      end

      case (state)
         RED_AMBER: amber = onehot;
         GREEN: begin
            red   = ~onehot;
            green = onehot;
         end
         AMBER: begin
            red   = ~onehot;
            amber = onehot;
         end
         WALK:    walk = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/traffic_junction.md
Name: traffic_junction

Overview:
- Parametrised successor to the single-approach traffic light: one controller sequences N road approaches at a junction in round-robin order, plus a shared pedestrian all-red walk phase.
- Per-phase durations are set by parameters in clock cycles. The block adds reset, an enable/freeze input and a latched pedestrian request.
- Sits between a free-running system clock and the lamp drivers; it is a pure Moore controller with registered state.

Parameters:
- N_APPROACH, 2, number of approaches (2..8)
- ALLRED_CYCLES, 1, all-red clearance length (>=1)
- RA_CYCLES, 2, red+amber length (>=1)
- GREEN_CYCLES, 8, green length (>=1)
- AMBER_CYCLES, 3, amber length (>=1)
- WALK_CYCLES, 6, pedestrian walk length (>=1)
- CNT_W, 8, phase counter width; every *_CYCLES value must be <= 2**CNT_W

Ports:
- clk, in, 1, system clock, rising edge
- rst, in, 1, synchronous active-high reset
- enable, in, 1, 1 = run; 0 = freeze state and counter
- ped_req, in, 1, pedestrian button, any pulse width >= 1 cycle
- red, out, N_APPROACH, per-approach red lamp
- amber, out, N_APPROACH, per-approach amber lamp
- green, out, N_APPROACH, per-approach green lamp
- walk, out, 1, pedestrian walk lamp
- active_idx, out, max(1,$clog2(N_APPROACH)), approach currently being served
- ped_pending, out, 1, latched pedestrian request

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values (clk edge with rst=1):
  - state=ALL_RED, counter loaded with ALLRED_CYCLES-1, active_idx=0, ped_pending=0.
  - Outputs: red=all ones, amber=0, green=0, walk=0.
  - rst takes priority over enable and ped_req. Reset mid-phase aborts the phase immediately.
- States: ALL_RED, RED_AMBER, GREEN, AMBER, WALK. Each state lasts exactly its *_CYCLES clock cycles while enable=1.
- Transitions, taken when the counter reaches 0 and enable=1. On every transition the counter reloads with the new state's length-1.
  - ALL_RED -> WALK if ped_pending=1, else RED_AMBER.
  - WALK -> ALL_RED; ped_pending cleared on this transition.
  - RED_AMBER -> GREEN -> AMBER.
  - AMBER -> ALL_RED; active_idx increments, wrapping N_APPROACH-1 -> 0.
- Lamp decode for active approach k = active_idx:
  - ALL_RED/WALK: red=all ones.
  - RED_AMBER: red[k]=1, amber[k]=1.
  - GREEN: red[k]=0, green[k]=1.
  - AMBER: red[k]=0, amber[k]=1.
  - Every non-active approach is red only.
  - walk=1 only in WALK.
- Safety invariants (checked every cycle):
  - At most one approach has green or amber set.
  - green[i] and red[i] are never both 1.
  - walk=1 implies red=all ones and green=0.
- ped_req handling:
  - Sets ped_pending on the next edge in any state except WALK; ignored while in WALK.
  - Repeated presses before service coalesce into one walk.
  - Simultaneous ped_req with the ALL_RED->RED_AMBER transition: the request is latched and served at the next ALL_RED.
- enable=0: state, counter, active_idx and outputs hold. ped_req still latches.
- Cycle period with defaults and no pedestrian: 14 cycles per approach, 28 for N=2. A walk adds WALK_CYCLES+ALLRED_CYCLES.
- Counter: down-counter, CNT_W bits, no wrap; load always takes priority over decrement.

Decomposition:
- Shared package/include traffic_pkg:
  - State encoding constants (ALL_RED=0, RED_AMBER=1, GREEN=2, AMBER=3, WALK=4, 3-bit).
  - Default phase-length constants.
- One sub-module, phase_timer:
  - Parametrised CNT_W down-counter.
  - Inputs: load, load_val, en. Output: done (counter==0).
  - The FSM, ped latch and lamp decode stay in traffic_junction.

Test Plan:
1. Reset and first cycle (N=2, defaults): hold rst for 3 cycles, release.
   - During reset: red=2'b11, amber=0, green=0, walk=0.
   - After 1 ALL_RED cycle: red=2'b11, amber=2'b01 for 2 cycles; then green=2'b01 for 8 cycles.
2. Full cycle with wrap (N=2): no ped_req, run 28 cycles.
   - Sequence is ALL_RED(1), RA(2), G(8), A(3) on approach 0, then the same on approach 1.
   - active_idx returns to 0 at cycle 28. Invariants hold throughout.
3. Pedestrian request: pulse ped_req for 1 cycle during approach 0 GREEN.
   - ped_pending=1 next cycle; approach 0 completes amber.
   - Then ALL_RED 1 cycle, walk=1 for 6 cycles with red=2'b11, ped_pending=0, ALL_RED 1 cycle, then approach 1 RA.
   - A second press during WALK produces no extra walk.
4. Enable freeze: drop enable for 5 cycles at cycle 4 of GREEN.
   - Outputs constant during the freeze.
   - Green lasts 8 enabled cycles total (13 wall-clock cycles).
5. Reset mid-operation: assert rst during AMBER of approach 1 with ped_pending=1.
   - Next edge: active_idx=0, ped_pending=0, red=all ones, state ALL_RED.
6. Parametric rerun: N_APPROACH=3, GREEN_CYCLES=4, AMBER_CYCLES=1.
   - active_idx steps 0->1->2->0 with a period of 3x8=24 cycles.
   - Never more than one non-red approach.
